// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = XLEN / BYTE_W;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_RMW_READ,
    S_RMW_WRITE,
    S_WRITE,
    S_DONE
  } lsu_state_t;

  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// Core request/response channel plus data RAM port.
interface lsu_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [31:0]           mem_rdata;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, mem_ren, mem_raddr,
    output mem_wen, mem_waddr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, mem_ren, mem_raddr,
    input  mem_wen, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Lane extract/extend for loads, lane merge for stores,
// and misalignment / illegal funct3 detection.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_data,
  output logic            err
);

  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  lane;
  logic [LANES-1:0] be;
  logic             mis_h;
  logic             mis_w;
  logic             bad_f3;

  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    load_data = '0;
    unique case (1'b1)
      funct3 == F3_LB:
        load_data = {{24{shifted[7]}}, shifted[7:0]};
      funct3 == F3_LH:
        load_data = {{16{shifted[15]}}, shifted[15:0]};
      funct3 == F3_LW:
        load_data = shifted;
      funct3 == F3_LBU:
        load_data = {24'd0, shifted[7:0]};
      funct3 == F3_LHU:
        load_data = {16'd0, shifted[15:0]};
      default:
        load_data = '0;
    endcase
  end

  // Replicate the store operand so every enabled lane sees it
  always_comb begin
    be   = '0;
    lane = wdata;
    unique case (1'b1)
      funct3 == F3_SB: begin
        be   = 4'b0001 << addr_lo;
        lane = {4{wdata[7:0]}};
      end
      funct3 == F3_SH: begin
        be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane = {2{wdata[15:0]}};
      end
      funct3 == F3_SW:
        be = 4'b1111;
      default:
        be = '0;
    endcase
    store_data = rdata;
    for (int k = 0; k < LANES; k++) begin
      if (be[k]) store_data[8*k +: 8] = lane[8*k +: 8];
    end
  end

  always_comb begin
    mis_h  = (funct3[1:0] == 2'b01) && addr_lo[0];
    mis_w  = (funct3[1:0] == 2'b10) && (addr_lo != 2'b00);
    bad_f3 = we ? (funct3 > 3'd2)
                : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    err    = mis_h || mis_w || bad_f3;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request FSM driving a word-wide synchronous RAM,
// with read-modify-write for sub-word stores.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  lsu_state_t            state;
  lsu_req_t              req_q;
  logic                  idle;
  logic                  a_we;
  logic [2:0]            a_f3;
  logic [1:0]            a_lo;
  logic [XLEN-1:0]       load_data;
  logic [XLEN-1:0]       store_data;
  logic                  err;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  unused_addr;

  assign idle          = (state == S_IDLE);
  assign bus.req_ready = idle;

  // Error checks look at the live request; data paths at the latched one
  assign a_we = idle ? bus.req_we : req_q.we;
  assign a_f3 = idle ? bus.req_funct3 : req_q.funct3;
  assign a_lo = idle ? bus.req_addr[1:0] : req_q.addr[1:0];

  lsu_align u_align (
    .we         (a_we),
    .funct3     (a_f3),
    .addr_lo    (a_lo),
    .wdata      (req_q.wdata),
    .rdata      (bus.mem_rdata),
    .load_data  (load_data),
    .store_data (store_data),
    .err        (err)
  );

  assign widx        = req_q.addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^req_q.addr[XLEN-1:ADDR_WIDTH+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      req_q          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            req_q.we     <= bus.req_we;
            req_q.funct3 <= bus.req_funct3;
            req_q.addr   <= bus.req_addr;
            req_q.wdata  <= bus.req_wdata;
            if (err) begin
              state          <= S_DONE;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else if (!bus.req_we) begin
              state <= S_READ;
            end else if (bus.req_funct3 == F3_SW) begin
              state <= S_WRITE;
            end else begin
              state <= S_RMW_READ;
            end
          end
        end
        S_READ:
          state <= S_CAPTURE;
        S_CAPTURE: begin
          state          <= S_DONE;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= load_data;
        end
        S_RMW_READ:
          state <= S_RMW_WRITE;
        S_RMW_WRITE, S_WRITE: begin
          state          <= S_DONE;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        S_DONE:
          state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

  // Decoded from state so a reset drops the write strobe at once
  always_comb begin
    bus.mem_ren   = (state == S_READ) || (state == S_RMW_READ);
    bus.mem_wen   = (state == S_WRITE) || (state == S_RMW_WRITE);
    bus.mem_raddr = bus.mem_ren ? widx : '0;
    bus.mem_waddr = bus.mem_wen ? widx : '0;
    bus.mem_wdata = bus.mem_wen ? store_data : '0;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a behavioural synchronous RAM.
module tb_lsu;
  import lsu_pkg::*;

  logic clk;
  logic rst;

  lsu_if #(.ADDR_WIDTH(8)) bus ();

  lsu #(.ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:255];

  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_raddr];
    if (bus.mem_wen) ram[bus.mem_waddr] <= bus.mem_wdata;
  end

  int n_chk;
  int n_fail;

  int          resp_cyc;
  int          resp_cnt;
  int          ren_cyc;
  int          ren_cnt;
  int          wen_cyc;
  int          wen_cnt;
  int          both_cnt;
  logic [31:0] wdata_seen;
  logic [31:0] rdata_seen;
  logic        err_seen;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    while (!bus.req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    resp_cyc = 0; resp_cnt = 0;
    ren_cyc = 0; ren_cnt = 0;
    wen_cyc = 0; wen_cnt = 0; both_cnt = 0;
    wdata_seen = '0; rdata_seen = '0; err_seen = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (resp_cnt == 0) begin
          resp_cyc   = k;
          rdata_seen = bus.resp_rdata;
          err_seen   = bus.resp_err;
        end
        resp_cnt++;
      end
      if (bus.mem_ren) begin
        if (ren_cnt == 0) ren_cyc = k;
        ren_cnt++;
      end
      if (bus.mem_wen) begin
        if (wen_cnt == 0) begin
          wen_cyc    = k;
          wdata_seen = bus.mem_wdata;
        end
        wen_cnt++;
      end
      if (bus.mem_ren && bus.mem_wen) both_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_load(input string tag, input logic [31:0] exp);
    chk({tag, "_resp_cyc"}, resp_cyc, 3);
    chk({tag, "_resp_cnt"}, resp_cnt, 1);
    chk({tag, "_rdata"}, rdata_seen, exp);
    chk({tag, "_err"}, {31'd0, err_seen}, 32'd0);
    chk({tag, "_ren_cyc"}, ren_cyc, 1);
    chk({tag, "_wen_cnt"}, wen_cnt, 0);
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_resp_cyc"}, resp_cyc, 1);
    chk({tag, "_err"}, {31'd0, err_seen}, 32'd1);
    chk({tag, "_rdata"}, rdata_seen, 32'd0);
    chk({tag, "_ren_cnt"}, ren_cnt, 0);
    chk({tag, "_wen_cnt"}, wen_cnt, 0);
  endtask

  int acc;
  int rsp;
  int bad;

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[4]         = 32'h8899AABB;
    bus.mem_rdata  = '0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    rst            = 1'b1;
    #12;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
    chk("rst_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
    chk("rst_mem_raddr", {24'd0, bus.mem_raddr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(1'b0, F3_LB, 32'h11, 32'h0);
    chk_load("lb11", 32'hFFFFFFAA);
    do_req(1'b0, F3_LBU, 32'h13, 32'h0);
    chk_load("lbu13", 32'h00000088);
    do_req(1'b0, F3_LH, 32'h12, 32'h0);
    chk_load("lh12", 32'hFFFF8899);
    do_req(1'b0, F3_LHU, 32'h10, 32'h0);
    chk_load("lhu10", 32'h0000AABB);
    do_req(1'b0, F3_LW, 32'h10, 32'h0);
    chk_load("lw10", 32'h8899AABB);

    do_req(1'b1, F3_SB, 32'h12, 32'h123456CC);
    chk("sb_ren_cyc", ren_cyc, 1);
    chk("sb_wen_cyc", wen_cyc, 2);
    chk("sb_wen_cnt", wen_cnt, 1);
    chk("sb_wdata", wdata_seen, 32'h88CCAABB);
    chk("sb_resp_cyc", resp_cyc, 3);
    chk("sb_rdata", rdata_seen, 32'd0);
    chk("sb_ram", ram[4], 32'h88CCAABB);

    do_req(1'b1, F3_SH, 32'h10, 32'h00001234);
    chk("sh_wdata", wdata_seen, 32'h88CC1234);
    chk("sh_resp_cyc", resp_cyc, 3);
    chk("sh_ram", ram[4], 32'h88CC1234);

    do_req(1'b1, F3_SW, 32'h10, 32'hDEADBEEF);
    chk("sw_ren_cnt", ren_cnt, 0);
    chk("sw_wen_cnt", wen_cnt, 1);
    chk("sw_wen_cyc", wen_cyc, 1);
    chk("sw_resp_cyc", resp_cyc, 2);
    chk("sw_ram", ram[4], 32'hDEADBEEF);

    do_req(1'b0, F3_LW, 32'h0000_0410, 32'h0);
    chk_load("lw_wrap", 32'hDEADBEEF);

    do_req(1'b0, F3_LW, 32'h11, 32'h0);
    chk_err("lw_mis");
    do_req(1'b1, F3_SH, 32'h13, 32'h0);
    chk_err("sh_mis");
    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    chk_err("ld_f3_011");
    do_req(1'b1, 3'b011, 32'h10, 32'h0);
    chk_err("st_f3_011");
    chk("err_ram", ram[4], 32'hDEADBEEF);

    // Held-high request: one accept per DONE, four-cycle loads
    acc = 0; rsp = 0; bad = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_LW;
    bus.req_addr   = 32'h10;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.req_valid && bus.req_ready) acc++;
      if (bus.resp_valid) rsp++;
      if (bus.mem_ren && bus.mem_wen) bad++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    chk("hold_accepts", acc, 3);
    chk("hold_resps", rsp, 3);
    chk("hold_ren_wen", bad, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset while SB is in its read phase
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_SB;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h00000055;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rmw_ren_before_rst", {31'd0, bus.mem_ren}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mid_rst_wen", {31'd0, bus.mem_wen}, 32'd0);
    chk("mid_rst_ren", {31'd0, bus.mem_ren}, 32'd0);
    wen_cnt = 0; resp_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst = 1'b0;
      if (bus.mem_wen) wen_cnt++;
      if (bus.resp_valid) resp_cnt++;
    end
    chk("mid_rst_wen_cnt", wen_cnt, 0);
    chk("mid_rst_resp_cnt", resp_cnt, 0);
    chk("mid_rst_ram", ram[4], 32'hDEADBEEF);
    do_req(1'b0, F3_LW, 32'h10, 32'h0);
    chk_load("lw_after_rst", 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit between the core's ALU result / rs2 path and the word-wide synchronous data RAM.
- Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW and the alignment checks, sign and zero extension, and read-modify-write for sub-word stores.
- Uses a valid/ready request channel and a single-cycle response pulse.
- Multi-cycle: the core stalls until the response arrives.

Parameters:
- ADDR_WIDTH, 8, word-index width of the data RAM (256 words). Byte address bits [ADDR_WIDTH+1:2] select the word.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  core presents a memory request
- req_ready  output  1  LSU can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 of the load/store
- req_addr  input  32  byte address (ALU result)
- req_wdata  input  32  store data (rs2)
- resp_valid  output  1  one-cycle pulse: request complete
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned access or illegal funct3, qualified by resp_valid
- mem_ren  output  1  RAM read enable
- mem_raddr  output  ADDR_WIDTH  RAM read word index
- mem_rdata  input  32  RAM read data, valid the cycle after mem_ren
- mem_wen  output  1  RAM write enable
- mem_waddr  output  ADDR_WIDTH  RAM write word index
- mem_wdata  output  32  RAM write data (full word)

Behaviour:
- Reset (async, rst=1): state=IDLE, all request fields registered to 0, resp_valid=0, resp_rdata=0, resp_err=0, mem_ren=0, mem_wen=0, mem addrs/wdata=0. req_ready=1 while in reset.
- Handshake: accept when req_valid && req_ready at a rising edge (cycle N). Register we, funct3, addr, wdata. req_valid in non-IDLE states is ignored.
- States: IDLE, READ, CAPTURE, RMW_READ, RMW_WRITE, WRITE, DONE.
- Error (checked at accept):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Load funct3 in {011,110,111}.
  - Store funct3 > 010.
  - Action: go to DONE at N+1 with resp_err=1 and resp_rdata=0. No mem_ren or mem_wen is ever asserted.
- Load: IDLE -> READ (N+1: mem_ren=1, mem_raddr=addr word) -> CAPTURE (N+2: extract lane from mem_rdata, extend, register) -> DONE (N+3: resp_valid=1).
- SW: IDLE -> WRITE (N+1: mem_wen=1, mem_wdata=wdata) -> DONE (N+2).
- SB/SH: IDLE -> RMW_READ (N+1: mem_ren=1) -> RMW_WRITE (N+2: mem_wen=1, mem_wdata=mem_rdata with the selected lane(s) replaced) -> DONE (N+3).
- DONE: resp_valid=1 for exactly one cycle, then IDLE. The next request can be accepted at DONE+1.
- Lanes are little-endian: byte k = bits [8k+7:8k], k=addr[1:0]. Halfword lane = addr[1].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - SB uses wdata[7:0]; SH uses wdata[15:0].
- Address bits above ADDR_WIDTH+1 are ignored (index wraps modulo 2^ADDR_WIDTH).
- mem_* outputs are decoded from state and registered request fields only. They are 0 in IDLE and DONE. mem_ren and mem_wen are never both high.
- Reset mid-operation: immediate return to IDLE, mem_wen drops asynchronously, no response is issued. A store is either written completely or not at all.
- resp_rdata and resp_err hold their values until the next DONE; consumers qualify them with resp_valid.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - lsu_state_t enum.
  - Width constants.
- Sub-module lsu_align (combinational): load lane extract/extend, store lane merge, and misalign/illegal detect. The FSM in lsu instantiates it.

Test Plan:
- RAM word index 4 = 0x8899AABB. LB addr 0x11 accepted at N -> resp_valid at N+3, rdata=0xFFFFFFAA, err=0. LBU 0x13 -> 0x00000088.
- Same word, LH 0x12 -> 0xFFFF8899. LHU 0x10 -> 0x0000AABB. LW 0x10 -> 0x8899AABB.
- SB addr 0x12, wdata 0x123456CC -> mem_ren at N+1, mem_wen at N+2 with mem_wdata=0x88CCAABB, resp at N+3. Then SH 0x10 with 0x00001234 -> word = 0x88CC1234.
- SW 0x10 wdata 0xDEADBEEF -> single mem_wen at N+1, resp at N+2, word=0xDEADBEEF. No mem_ren during the SW.
- LW 0x11, SH 0x13, load funct3=011 -> each gives resp at N+1 with err=1, rdata=0, no mem_ren/mem_wen. req_valid held high during busy -> exactly one accept per DONE.
- Assert rst during RMW_READ of SB 0x10 -> mem_wen never asserts, no resp_valid, word unchanged, req_ready=1 immediately, and a new LW is accepted after release.
